// File: rtl/relay.sv
// One 4PDT relay: registered armature FSM with timed pull-in/drop-out transit.
// Contacts are combinational from in_n gated by the registered state; zero data latency, no backpressure.
module relay #(
  parameter int unsigned PULL_IN_CYCLES  = 2,
  parameter int unsigned DROP_OUT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic control,
  input  logic in_0,
  input  logic in_1,
  input  logic in_2,
  input  logic in_3,
  output logic out_hi_0,
  output logic out_hi_1,
  output logic out_hi_2,
  output logic out_hi_3,
  output logic out_lo_0,
  output logic out_lo_1,
  output logic out_lo_2,
  output logic out_lo_3,
  output logic energized,
  output logic in_transit
);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PULLING   = 2'd1,
    ENERGIZED = 2'd2,
    DROPPING  = 2'd3
  } state_t;

  localparam int unsigned PULL_LOAD_I = (PULL_IN_CYCLES  > 0) ? PULL_IN_CYCLES  - 1 : 0;
  localparam int unsigned DROP_LOAD_I = (DROP_OUT_CYCLES > 0) ? DROP_OUT_CYCLES - 1 : 0;
  localparam logic [7:0]  PULL_LOAD   = 8'(PULL_LOAD_I);
  localparam logic [7:0]  DROP_LOAD   = 8'(DROP_LOAD_I);
  localparam bit          PULL_ZERO   = (PULL_IN_CYCLES  == 0);
  localparam bit          DROP_ZERO   = (DROP_OUT_CYCLES == 0);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] in_v;
  logic       sel_hi, sel_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (control) begin
          if (PULL_ZERO) begin
            state_d = ENERGIZED;
          end else begin
            state_d = PULLING;
            cnt_d   = PULL_LOAD;
          end
        end
      end
      PULLING: begin
        // Coil dropped before the armature seated: fall back without ever closing.
        if (!control) begin
          state_d = RELEASED;
        end else if (cnt_q == 8'd0) begin
          state_d = ENERGIZED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ENERGIZED: begin
        if (!control) begin
          if (DROP_ZERO) begin
            state_d = RELEASED;
          end else begin
            state_d = DROPPING;
            cnt_d   = DROP_LOAD;
          end
        end
      end
      DROPPING: begin
        if (control) begin
          state_d = ENERGIZED;
        end else if (cnt_q == 8'd0) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs depend only on state_q and in_n, never on control, so chains stay loop-free.
  assign sel_hi     = (state_q == ENERGIZED);
  assign sel_lo     = (state_q == RELEASED);
  assign energized  = sel_hi;
  assign in_transit = (state_q == PULLING) || (state_q == DROPPING);

  assign in_v = {in_3, in_2, in_1, in_0};

  assign {out_hi_3, out_hi_2, out_hi_1, out_hi_0} = in_v & {4{sel_hi}};
  assign {out_lo_3, out_lo_2, out_lo_1, out_lo_0} = in_v & {4{sel_lo}};

endmodule

// File: tb/tb_relay.sv
// Directed bench for relay: main 2/2 instance, a 0/0 instance, and an 8-deep zero-detect chain.
module tb_relay;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Main instance, delays 2/2
  logic       ctl = 1'b0;
  logic [3:0] in_v = 4'b1010;
  logic [3:0] hi, lo;
  logic       en, tr;

  relay #(.PULL_IN_CYCLES(2), .DROP_OUT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .control(ctl),
    .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .out_hi_0(hi[0]), .out_hi_1(hi[1]), .out_hi_2(hi[2]), .out_hi_3(hi[3]),
    .out_lo_0(lo[0]), .out_lo_1(lo[1]), .out_lo_2(lo[2]), .out_lo_3(lo[3]),
    .energized(en), .in_transit(tr)
  );

  // Zero-delay instance
  logic       z_ctl = 1'b0;
  logic [3:0] z_in = 4'b0110;
  logic [3:0] z_hi, z_lo;
  logic       z_en, z_tr;

  relay #(.PULL_IN_CYCLES(0), .DROP_OUT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .control(z_ctl),
    .in_0(z_in[0]), .in_1(z_in[1]), .in_2(z_in[2]), .in_3(z_in[3]),
    .out_hi_0(z_hi[0]), .out_hi_1(z_hi[1]), .out_hi_2(z_hi[2]), .out_hi_3(z_hi[3]),
    .out_lo_0(z_lo[0]), .out_lo_1(z_lo[1]), .out_lo_2(z_lo[2]), .out_lo_3(z_lo[3]),
    .energized(z_en), .in_transit(z_tr)
  );

  // Zero-detect chain: out_lo_3 of relay g feeds in_3 of relay g+1
  logic [7:0] cnt = 8'd0;
  logic [7:0] ch_in3;
  logic [3:0] ch_hi [8];
  logic [3:0] ch_lo [8];
  logic [7:0] ch_en, ch_tr;

  assign ch_in3[0] = 1'b1;
  for (genvar g = 1; g < 8; g++) begin : g_link
    assign ch_in3[g] = ch_lo[g-1][3];
  end

  for (genvar g = 0; g < 8; g++) begin : g_chain
    relay u_r (
      .clk(clk), .reset(reset), .control(cnt[g]),
      .in_0(1'b0), .in_1(1'b0), .in_2(1'b0), .in_3(ch_in3[g]),
      .out_hi_0(ch_hi[g][0]), .out_hi_1(ch_hi[g][1]), .out_hi_2(ch_hi[g][2]), .out_hi_3(ch_hi[g][3]),
      .out_lo_0(ch_lo[g][0]), .out_lo_1(ch_lo[g][1]), .out_lo_2(ch_lo[g][2]), .out_lo_3(ch_lo[g][3]),
      .energized(ch_en[g]), .in_transit(ch_tr[g])
    );
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of main DUT: {en, tr}, hi, lo
  task automatic check_main(input string tag, input logic e, input logic t,
                            input logic [3:0] h, input logic [3:0] l);
    check({tag, ".energized"}, {3'b0, en}, {3'b0, e});
    check({tag, ".in_transit"}, {3'b0, tr}, {3'b0, t});
    check({tag, ".out_hi"}, hi, h);
    check({tag, ".out_lo"}, lo, l);
  endtask

  initial begin
    // Reset
    #12;
    check_main("reset", 1'b0, 1'b0, 4'b0000, 4'b1010);
    check("reset.z_lo", z_lo, 4'b0110);
    check("reset.chain_zero", {3'b0, ch_lo[7][3]}, 4'b0001);
    @(negedge clk);
    reset = 1'b0;

    // Released data path follows in_n with no clock
    in_v = 4'b0011;
    #1;
    check_main("rel_prop", 1'b0, 1'b0, 4'b0000, 4'b0011);

    // Pull-in, N=2
    ctl = 1'b1;
    edge1();
    check_main("pull_e0", 1'b0, 1'b1, 4'b0000, 4'b0000);
    in_v = 4'b1100;
    #1;
    check_main("pull_e0_in", 1'b0, 1'b1, 4'b0000, 4'b0000);
    edge1();
    check_main("pull_e1", 1'b0, 1'b1, 4'b0000, 4'b0000);
    edge1();
    check_main("energ", 1'b1, 1'b0, 4'b1100, 4'b0000);
    in_v = 4'b1001;
    #1;
    check_main("energ_prop", 1'b1, 1'b0, 4'b1001, 4'b0000);

    // Drop-out, N=2
    ctl = 1'b0;
    edge1();
    check_main("drop_e0", 1'b0, 1'b1, 4'b0000, 4'b0000);
    edge1();
    check_main("drop_e1", 1'b0, 1'b1, 4'b0000, 4'b0000);
    edge1();
    check_main("released", 1'b0, 1'b0, 4'b0000, 4'b1001);

    // Pull-in abort after one edge
    ctl = 1'b1;
    edge1();
    check_main("pabort_pull", 1'b0, 1'b1, 4'b0000, 4'b0000);
    ctl = 1'b0;
    edge1();
    check_main("pabort_rel", 1'b0, 1'b0, 4'b0000, 4'b1001);
    edge1();
    check_main("pabort_stay", 1'b0, 1'b0, 4'b0000, 4'b1001);

    // Drop-out abort
    ctl = 1'b1;
    edge1(); edge1(); edge1();
    check_main("dabort_energ", 1'b1, 1'b0, 4'b1001, 4'b0000);
    ctl = 1'b0;
    edge1();
    check_main("dabort_drop", 1'b0, 1'b1, 4'b0000, 4'b0000);
    ctl = 1'b1;
    edge1();
    check_main("dabort_energ2", 1'b1, 1'b0, 4'b1001, 4'b0000);

    // Async reset mid-transit
    ctl = 1'b0;
    edge1();
    check_main("ares_drop", 1'b0, 1'b1, 4'b0000, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    check_main("ares_forced", 1'b0, 1'b0, 4'b0000, 4'b1001);
    @(negedge clk);
    reset = 1'b0;

    // Zero-delay instance follows control one edge later, never in transit
    begin
      logic [7:0] pat;
      pat = 8'b10110100;
      for (int i = 0; i < 8; i++) begin
        z_ctl = pat[i];
        edge1();
        check($sformatf("zero_en_%0d", i), {3'b0, z_en}, {3'b0, pat[i]});
        check($sformatf("zero_tr_%0d", i), {3'b0, z_tr}, 4'b0000);
        check($sformatf("zero_hi_%0d", i), z_hi, pat[i] ? 4'b0110 : 4'b0000);
        check($sformatf("zero_lo_%0d", i), z_lo, pat[i] ? 4'b0000 : 4'b0110);
      end
      z_ctl = 1'b0;
      edge1();
    end

    // Chain zero detect
    check("chain_all0", {3'b0, ch_lo[7][3]}, 4'b0001);
    begin
      logic [7:0] bits [3];
      bits[0] = 8'b0000_0001;
      bits[1] = 8'b0001_0000;
      bits[2] = 8'b1000_0000;
      for (int k = 0; k < 3; k++) begin
        cnt = bits[k];
        edge1();
        check($sformatf("chain_b%0d_transit", k), {3'b0, ch_lo[7][3]}, 4'b0000);
        edge1(); edge1();
        check($sformatf("chain_b%0d_set", k), {3'b0, ch_lo[7][3]}, 4'b0000);
        check($sformatf("chain_b%0d_en", k), {3'b0, |(ch_en & bits[k])}, 4'b0001);
        cnt = 8'd0;
        edge1(); edge1();
        check($sformatf("chain_b%0d_drop", k), {3'b0, ch_lo[7][3]}, 4'b0000);
        edge1();
        check($sformatf("chain_b%0d_clear", k), {3'b0, ch_lo[7][3]}, 4'b0001);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Break-before-make: no pole ever drives both contacts
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      assert ((hi & lo) === 4'b0000) passed++;
      else $error("FAIL bbm: got hi=%b lo=%b expected no overlap", hi, lo);
    end
  end

endmodule
